s_box_arbiter: RTL and testbench

- Shares one S_box_memory instance (32-bit word in, 32-bit word out, registered on negedge clk_i) between two requesters: key expansion (KE, SubWord) and the round datapath (DP, SubBytes column).
- Arbitrates, registers the winning word onto the memory input, captures the memory output and returns it to the owner with a valid pulse.
- Pipelined: one issue per cycle overall, two-edge latency.

---
 rtl/aes_pkg.sv | 11 +
 rtl/s_box_arbiter_pkg.sv | 15 +
 rtl/s_box_arbiter_if.sv | 28 ++
 rtl/S_box_memory.sv | 42 ++++
 rtl/s_box_arb_pick.sv | 27 ++
 rtl/s_box_arbiter.sv | 85 ++++++++
 tb/tb_s_box_arbiter.sv | 236 +++++++++++++++++++++++
 7 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and the owner encoding used by the S-box arbiter.
package aes_pkg;

    localparam int BYTE_WIDTH      = 8;
    localparam int FOUR_BYTE_WIDTH = 32;
    localparam int S_BOX_SIZE      = 256;

    localparam logic OWNER_KE = 1'b0;
    localparam logic OWNER_DP = 1'b1;

endpackage

// File: rtl/s_box_arbiter_pkg.sv
// Arbiter-local types: owner enum built on the shared AES owner encoding.
package s_box_arbiter_pkg;

    import aes_pkg::*;

    typedef enum logic {
        OWN_KE = OWNER_KE,
        OWN_DP = OWNER_DP
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_KE) ? OWN_DP : OWN_KE;
    endfunction

endpackage

// File: rtl/s_box_arbiter_if.sv
// Requester-side handshake bundle for the S-box arbiter (KE and DP channels).
interface s_box_arbiter_if #(
    parameter int WORD_W = aes_pkg::FOUR_BYTE_WIDTH
);

    logic              ke_req_i;
    logic [WORD_W-1:0] ke_word_i;
    logic              ke_gnt_o;
    logic              ke_valid_o;
    logic [WORD_W-1:0] ke_word_o;

    logic              dp_req_i;
    logic [WORD_W-1:0] dp_word_i;
    logic              dp_gnt_o;
    logic              dp_valid_o;
    logic [WORD_W-1:0] dp_word_o;

    modport master (
        output ke_req_i, ke_word_i, dp_req_i, dp_word_i,
        input  ke_gnt_o, ke_valid_o, ke_word_o, dp_gnt_o, dp_valid_o, dp_word_o
    );

    modport slave (
        input  ke_req_i, ke_word_i, dp_req_i, dp_word_i,
        output ke_gnt_o, ke_valid_o, ke_word_o, dp_gnt_o, dp_valid_o, dp_word_o
    );

endinterface

// File: rtl/S_box_memory.sv
// AES S-box applied to four bytes; output registered on the falling clock edge.
module S_box_memory
    import aes_pkg::*;
(
    input  logic                       clk_i,
    input  logic [FOUR_BYTE_WIDTH-1:0] W_i,
    output logic [FOUR_BYTE_WIDTH-1:0] W_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = x;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_ff @(negedge clk_i) begin
        for (int b = 0; b < FOUR_BYTE_WIDTH / BYTE_WIDTH; b++) begin
            W_o[b*BYTE_WIDTH +: BYTE_WIDTH] <= sbox_byte(W_i[b*BYTE_WIDTH +: BYTE_WIDTH]);
        end
    end

endmodule

// File: rtl/s_box_arb_pick.sv
// Combinational winner selection between the KE and DP requesters.
module s_box_arb_pick
    import s_box_arbiter_pkg::*;
(
    input  logic   ke_elig,
    input  logic   dp_elig,
    input  logic   ke_first,
    input  logic   rr_en,
    input  owner_e rr_ptr,
    output owner_e win,
    output logic   win_v
);

    owner_e pref;

    always_comb begin
        pref  = rr_en ? rr_ptr : (ke_first ? OWN_KE : OWN_DP);
        win_v = ke_elig | dp_elig;
        win   = OWN_KE;
        if (ke_elig && dp_elig) begin
            win = pref;
        end else if (dp_elig) begin
            win = OWN_DP;
        end
    end

endmodule

// File: rtl/s_box_arbiter.sv
// Shares one S_box_memory between key expansion and the round datapath.
// Build option SBOX_ARB_RR_EN: round-robin tie-break instead of fixed KE_FIRST priority.
module s_box_arbiter
    import aes_pkg::*;
    import s_box_arbiter_pkg::*;
#(
    parameter int WORD_W   = FOUR_BYTE_WIDTH,
    parameter bit KE_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    s_box_arbiter_if.slave    bus,
    output logic [WORD_W-1:0] sbox_word_o,
    input  logic [WORD_W-1:0] sbox_word_i,
    output logic              busy_o
);

    logic   ke_elig;
    logic   dp_elig;
    logic   win_v;
    logic   rr_en;
    owner_e win;
    owner_e rr_ptr;
    owner_e owner_q;
    logic   issue_v_q;

    // A requester in its grant cycle is already updating its word, so it sits out.
    assign ke_elig = bus.ke_req_i & ~bus.ke_gnt_o;
    assign dp_elig = bus.dp_req_i & ~bus.dp_gnt_o;
    assign busy_o  = issue_v_q;

    s_box_arb_pick u_pick (
        .ke_elig  (ke_elig),
        .dp_elig  (dp_elig),
        .ke_first (KE_FIRST),
        .rr_en    (rr_en),
        .rr_ptr   (rr_ptr),
        .win      (win),
        .win_v    (win_v)
    );

`ifdef SBOX_ARB_RR_EN
    assign rr_en = 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rr_ptr <= OWN_KE;
        end else if (win_v) begin
            rr_ptr <= other_owner(win);
        end
    end
`else
    assign rr_en  = 1'b0;
    assign rr_ptr = OWN_KE;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            issue_v_q      <= 1'b0;
            owner_q        <= OWN_KE;
            sbox_word_o    <= '0;
            bus.ke_gnt_o   <= 1'b0;
            bus.dp_gnt_o   <= 1'b0;
            bus.ke_valid_o <= 1'b0;
            bus.dp_valid_o <= 1'b0;
            bus.ke_word_o  <= '0;
            bus.dp_word_o  <= '0;
        end else begin
            issue_v_q    <= win_v;
            bus.ke_gnt_o <= win_v && (win == OWN_KE);
            bus.dp_gnt_o <= win_v && (win == OWN_DP);
            if (win_v) begin
                owner_q     <= win;
                sbox_word_o <= (win == OWN_KE) ? bus.ke_word_i : bus.dp_word_i;
            end

            // Memory output is settled here: it sampled sbox_word_o on the falling edge.
            bus.ke_valid_o <= issue_v_q && (owner_q == OWN_KE);
            bus.dp_valid_o <= issue_v_q && (owner_q == OWN_DP);
            if (issue_v_q && (owner_q == OWN_KE)) bus.ke_word_o <= sbox_word_i;
            if (issue_v_q && (owner_q == OWN_DP)) bus.dp_word_o <= sbox_word_i;
        end
    end

endmodule

// File: tb/tb_s_box_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_s_box_arbiter;

    import aes_pkg::*;

    localparam int W        = FOUR_BYTE_WIDTH;
    localparam bit KE_FIRST = 1'b1;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [W-1:0] sbox_word_o;
    logic [W-1:0] sbox_word_i;
    logic         busy_o;

    s_box_arbiter_if #(.WORD_W(W)) bus ();

    s_box_arbiter #(.WORD_W(W), .KE_FIRST(KE_FIRST)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .bus         (bus),
        .sbox_word_o (sbox_word_o),
        .sbox_word_i (sbox_word_i),
        .busy_o      (busy_o)
    );

    S_box_memory u_mem (
        .clk_i (clk_i),
        .W_i   (sbox_word_o),
        .W_o   (sbox_word_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] sbox_tbl [256];

    // Reference model: what the outputs must be in the current cycle.
    logic         m_ke_gnt, m_dp_gnt, m_ke_valid, m_dp_valid;
    logic [W-1:0] m_ke_word, m_dp_word, m_sbox;
    logic         m_pend_v, m_pend_dp;
    logic [W-1:0] m_pend_word;
    logic         m_ptr_dp;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Standard S-box construction by walking the field with generator 3 and its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
            sbox_tbl[p] = x;
        end while (p != 8'h01);
        sbox_tbl[0] = 8'h63;
    endtask

    function automatic logic [W-1:0] sub_word(input logic [W-1:0] w);
        return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
    endfunction

    function automatic logic ke_wins_tie();
`ifdef SBOX_ARB_RR_EN
        return !m_ptr_dp;
`else
        return KE_FIRST;
`endif
    endfunction

    task automatic model_reset();
        m_ke_gnt = 0; m_dp_gnt = 0; m_ke_valid = 0; m_dp_valid = 0;
        m_ke_word = '0; m_dp_word = '0; m_sbox = '0;
        m_pend_v = 0; m_pend_dp = 0; m_pend_word = '0; m_ptr_dp = 0;
    endtask

    // Check the current cycle, advance the model, and return #1 after the next rising edge.
    task automatic cycle();
        logic ke_el, dp_el, any, win_dp;
        @(negedge clk_i);
        chk("ke_gnt",   bus.ke_gnt_o,   m_ke_gnt);
        chk("dp_gnt",   bus.dp_gnt_o,   m_dp_gnt);
        chk("ke_valid", bus.ke_valid_o, m_ke_valid);
        chk("dp_valid", bus.dp_valid_o, m_dp_valid);
        chk("ke_word",  bus.ke_word_o,  m_ke_word);
        chk("dp_word",  bus.dp_word_o,  m_dp_word);
        chk("sbox_word", sbox_word_o,   m_sbox);
        chk("busy",     busy_o,         m_pend_v);
        if (!rst_n_i) begin
            model_reset();
        end else begin
            ke_el  = bus.ke_req_i && !m_ke_gnt;
            dp_el  = bus.dp_req_i && !m_dp_gnt;
            any    = ke_el || dp_el;
            win_dp = (ke_el && dp_el) ? !ke_wins_tie() : dp_el;
            // The word granted in this cycle comes back substituted next cycle.
            m_ke_valid = m_pend_v && !m_pend_dp;
            m_dp_valid = m_pend_v && m_pend_dp;
            if (m_ke_valid) m_ke_word = sub_word(m_pend_word);
            if (m_dp_valid) m_dp_word = sub_word(m_pend_word);
            m_ke_gnt = any && !win_dp;
            m_dp_gnt = any && win_dp;
            if (any) m_sbox = win_dp ? bus.dp_word_i : bus.ke_word_i;
            m_pend_v    = any;
            m_pend_dp   = win_dp;
            m_pend_word = m_sbox;
            if (any) m_ptr_dp = !win_dp;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        build_sbox();
        model_reset();
        rst_n_i       = 1'b0;
        bus.ke_req_i  = 1'b1;
        bus.ke_word_i = 32'h00010253;
        bus.dp_req_i  = 1'b0;
        bus.dp_word_i = '0;
        @(posedge clk_i);
        #1;

        // Reset held with KE requesting: nothing moves.
        repeat (3) cycle();
        chk("rst_ke_gnt", bus.ke_gnt_o, 0);
        chk("rst_sbox", sbox_word_o, 0);
        rst_n_i = 1'b1;
        cycle();
        chk("first_ke_gnt", bus.ke_gnt_o, 1);
        bus.ke_req_i = 1'b0;
        cycle();
        chk("ke_single_valid", bus.ke_valid_o, 1);
        chk("ke_single_word", bus.ke_word_o, 32'h637c77ed);
        chk("ke_single_dp_valid", bus.dp_valid_o, 0);
        repeat (2) cycle();

        // Both requesting continuously.
        bus.ke_req_i = 1'b1; bus.ke_word_i = 32'h00000000;
        bus.dp_req_i = 1'b1; bus.dp_word_i = 32'hffffffff;
        for (int k = 1; k <= 8; k++) begin
            cycle();
`ifndef SBOX_ARB_RR_EN
            chk("cont_ke_gnt", bus.ke_gnt_o, (k % 2) == 1);
`endif
            chk("cont_busy", busy_o, 1);
            if (bus.ke_valid_o) chk("cont_ke_res", bus.ke_word_o, 32'h63636363);
            if (bus.dp_valid_o) chk("cont_dp_res", bus.dp_word_o, 32'h16161616);
        end
        bus.ke_req_i = 1'b0;
        bus.dp_req_i = 1'b0;
        repeat (3) cycle();

`ifdef SBOX_ARB_RR_EN
        for (int r = 0; r < 2; r++) begin
            logic exp_ke;
            exp_ke = !m_ptr_dp;
            bus.ke_req_i = 1'b1; bus.ke_word_i = $urandom;
            bus.dp_req_i = 1'b1; bus.dp_word_i = $urandom;
            cycle();
            chk("rr_first_ke", bus.ke_gnt_o, exp_ke);
            if (bus.ke_gnt_o) bus.ke_req_i = 1'b0;
            if (bus.dp_gnt_o) bus.dp_req_i = 1'b0;
            cycle();
            chk("rr_second_ke", bus.ke_gnt_o, !exp_ke);
            bus.ke_req_i = 1'b0;
            bus.dp_req_i = 1'b0;
            repeat (3) cycle();
        end
`endif

        // Reset right after a DP grant drops the in-flight result.
        bus.dp_req_i = 1'b1; bus.dp_word_i = 32'h10101010;
        cycle();
        chk("mid_dp_gnt", bus.dp_gnt_o, 1);
        bus.dp_req_i = 1'b0;
        rst_n_i = 1'b0;
        cycle();
        chk("mid_dp_valid", bus.dp_valid_o, 0);
        chk("mid_dp_word", bus.dp_word_o, 0);
        rst_n_i = 1'b1;
        cycle();
        chk("mid_dp_valid_after", bus.dp_valid_o, 0);
        cycle();

        // Back-to-back from KE with req held.
        bus.ke_req_i = 1'b1; bus.ke_word_i = 32'h01010101;
        cycle();
        chk("b2b_gnt1", bus.ke_gnt_o, 1);
        bus.ke_word_i = 32'h53535353;
        cycle();
        chk("b2b_no_dup", bus.ke_gnt_o, 0);
        chk("b2b_res1", bus.ke_word_o, 32'h7c7c7c7c);
        cycle();
        chk("b2b_gnt2", bus.ke_gnt_o, 1);
        bus.ke_req_i = 1'b0;
        cycle();
        chk("b2b_valid2", bus.ke_valid_o, 1);
        chk("b2b_res2", bus.ke_word_o, 32'hedededed);
        repeat (2) cycle();

        // Random traffic that follows the request protocol, with rare drops and resets.
        for (int i = 0; i < 400; i++) begin
            rst_n_i = ($urandom_range(0, 99) >= 2);
            if (m_ke_gnt || !bus.ke_req_i) begin
                bus.ke_req_i  = ($urandom_range(0, 99) < 60);
                bus.ke_word_i = $urandom;
            end else if ($urandom_range(0, 99) < 5) begin
                bus.ke_req_i = 1'b0;
            end
            if (m_dp_gnt || !bus.dp_req_i) begin
                bus.dp_req_i  = ($urandom_range(0, 99) < 60);
                bus.dp_word_i = $urandom;
            end else if ($urandom_range(0, 99) < 5) begin
                bus.dp_req_i = 1'b0;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
